a23_gc_out_reader: RTL and testbench

Bus initiator that drains the garbled-circuit output region after the a23 core terminates. On start it issues sequential word reads at 0x03000000 + 4·k, k = 0..OUT_MEM_SIZE-1, on the same memory bus the core uses. Each word goes out on a valid/ready stream, so results leave the design serially instead of through the wide flat output vector. It sits beside the core at the memory subsystem. The integrator muxes the bus to this block while `o_bus_own` is high.

---
 rtl/a23_gc_pkg.sv | 20 ++
 rtl/a23_gc_out_reader.sv | 97 +++++++++
 tb/tb_a23_gc_out_reader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/a23_gc_pkg.sv
// Shared constants for the a23 garbled-circuit memory map and the output reader.
// Region selects occupy address bits [31:24].
package a23_gc_pkg;

  localparam logic [7:0] CODE      = 8'h00;
  localparam logic [7:0] GARBLER   = 8'h01;
  localparam logic [7:0] EVALUATOR = 8'h02;
  localparam logic [7:0] OUT       = 8'h03;
  localparam logic [7:0] STACK     = 8'h04;

  localparam logic [31:0] ADR_OUT = {OUT, 24'h000000};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } rd_state_e;

endpackage

// File: rtl/a23_gc_out_reader.sv
// Drains the garbled-circuit output region word by word onto a valid/ready stream.
// The bus is borrowed for one cycle per word so the core can use it in between.
module a23_gc_out_reader
  import a23_gc_pkg::*;
#(
  parameter int          OUT_MEM_SIZE = 64,
  parameter logic [31:0] BASE_ADDR    = ADR_OUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  output logic        o_bus_own,
  output logic [31:0] o_m_address,
  output logic        o_m_write_en,
  output logic [3:0]  o_m_byte_enable,
  input  logic [31:0] i_m_read,
  output logic [31:0] o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_last,
  output logic        o_done
);

  localparam int               IDX_W    = (OUT_MEM_SIZE > 1) ? $clog2(OUT_MEM_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_MEM_SIZE - 1);

  rd_state_e        state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [31:0]      data_reg, data_next;
  logic             is_last;

  assign is_last      = (idx_reg == LAST_IDX);
  assign o_m_write_en = 1'b0;
  assign o_data       = data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    data_next       = data_reg;
    o_bus_own       = 1'b0;
    o_m_address     = 32'h0;
    o_m_byte_enable = 4'b0000;
    o_valid         = 1'b0;
    o_last          = 1'b0;
    o_done          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          state_next = READ;
          idx_next   = '0;
        end
      end
      READ: begin
        o_bus_own       = 1'b1;
        o_m_address     = BASE_ADDR + (32'(idx_reg) << 2);
        o_m_byte_enable = 4'b1111;
        data_next       = i_m_read;
        state_next      = HOLD;
      end
      HOLD: begin
        o_valid = 1'b1;
        o_last  = is_last;
        if (i_ready) begin
          if (is_last) begin
            // Clear the word so the stream output reads 0 once the pass is over.
            state_next = DONE;
            data_next  = '0;
          end else begin
            state_next = READ;
            idx_next   = idx_reg + IDX_W'(1);
          end
        end
      end
      DONE: begin
        o_done = 1'b1;
        if (i_start) begin
          state_next = READ;
          idx_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_a23_gc_out_reader.sv
// Directed bench for the output reader: scoreboard of expected words per pass,
// covering reset, full drains, backpressure, ignored start, mid-pass reset and size 1.
module tb_a23_gc_out_reader;
  import a23_gc_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, ready, sel;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  logic        a_own, a_we, a_valid, a_last, a_done;
  logic [31:0] a_addr, a_rd, a_data;
  logic [3:0]  a_be;
  logic        b_own, b_we, b_valid, b_last, b_done;
  logic [31:0] b_addr, b_rd, b_data;
  logic [3:0]  b_be;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 + ((a - ADR_OUT) >> 2);
  endfunction

  assign a_rd = mem_word(a_addr);
  assign b_rd = mem_word(b_addr);

  a23_gc_out_reader #(.OUT_MEM_SIZE(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(start & ~sel), .o_bus_own(a_own),
    .o_m_address(a_addr), .o_m_write_en(a_we), .o_m_byte_enable(a_be),
    .i_m_read(a_rd), .o_data(a_data), .o_valid(a_valid), .i_ready(ready & ~sel),
    .o_last(a_last), .o_done(a_done)
  );

  a23_gc_out_reader #(.OUT_MEM_SIZE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(start & sel), .o_bus_own(b_own),
    .o_m_address(b_addr), .o_m_write_en(b_we), .o_m_byte_enable(b_be),
    .i_m_read(b_rd), .o_data(b_data), .o_valid(b_valid), .i_ready(ready & sel),
    .o_last(b_last), .o_done(b_done)
  );

  logic        own, we, valid, last, done;
  logic [31:0] addr, data;
  logic [3:0]  be;
  assign own   = sel ? b_own   : a_own;
  assign we    = sel ? b_we    : a_we;
  assign valid = sel ? b_valid : a_valid;
  assign last  = sel ? b_last  : a_last;
  assign done  = sel ? b_done  : a_done;
  assign addr  = sel ? b_addr  : a_addr;
  assign data  = sel ? b_data  : a_data;
  assign be    = sel ? b_be    : a_be;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_own"},   {31'd0, own},   32'd0);
    chk({tag, "_addr"},  addr,           32'd0);
    chk({tag, "_we"},    {31'd0, we},    32'd0);
    chk({tag, "_be"},    {28'd0, be},    32'd0);
    chk({tag, "_data"},  data,           32'd0);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_last"},  {31'd0, last},  32'd0);
    chk({tag, "_done"},  {31'd0, done},  32'd0);
  endtask

  // One drain pass. bp_word/ign_word/abort_word = -1 disables that feature.
  task automatic run_pass(input int n, input bit from_done, input int bp_word,
                          input int bp_cycles, input int ign_word, input int abort_word,
                          input int exp_done_cycle);
    exp_t e;
    int cyc_n;
    int words;
    words = 0;
    for (int k = 0; k < n; k++) begin
      e.addr = ADR_OUT + 32'(4 * k);
      e.data = 32'hA500_0000 + 32'(k);
      e.last = (k == n - 1);
      sb.push_back(e);
    end
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc_n = 1;
    if (from_done) chk("done_clear", {31'd0, done}, 32'd0);
    for (int k = 0; k < n; k++) begin
      e = sb[0];
      if (k == abort_word) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        $display("pass n=%0d aborted at word %0d", n, k);
        return;
      end
      chk("read_own",    {31'd0, own},   32'd1);
      chk("read_addr",   addr,           e.addr);
      chk("read_region", {24'd0, addr[31:24]}, {24'd0, OUT});
      chk("read_be",     {28'd0, be},    32'hF);
      chk("read_we",     {31'd0, we},    32'd0);
      chk("read_valid",  {31'd0, valid}, 32'd0);
      if (k == bp_word) ready = 1'b0;
      @(negedge clk);
      cyc_n++;
      chk("hold_valid", {31'd0, valid}, 32'd1);
      chk("hold_own",   {31'd0, own},   32'd0);
      chk("hold_addr",  addr,           32'd0);
      chk("hold_be",    {28'd0, be},    32'd0);
      chk("hold_data",  data,           e.data);
      chk("hold_last",  {31'd0, last},  {31'd0, e.last});
      if (k == bp_word) begin
        repeat (bp_cycles - 1) begin
          @(negedge clk);
          cyc_n++;
          chk("bp_valid", {31'd0, valid}, 32'd1);
          chk("bp_data",  data,           e.data);
          chk("bp_own",   {31'd0, own},   32'd0);
        end
        ready = 1'b1;
      end
      if (k == ign_word) start = 1'b1;
      $display("word %0d addr=%h data=%h last=%0d", k, e.addr, data, last);
      void'(sb.pop_front());
      words++;
      @(negedge clk);
      cyc_n++;
      start = 1'b0;
    end
    chk("done_set",   {31'd0, done},  32'd1);
    chk("done_valid", {31'd0, valid}, 32'd0);
    chk("done_own",   {31'd0, own},   32'd0);
    chk("sb_empty",   32'(sb.size()), 32'd0);
    chk("word_count", 32'(words),     32'(n));
    if (exp_done_cycle > 0) chk("done_cycle", 32'(cyc_n), 32'(exp_done_cycle));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    sel   = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_own", {31'd0, own}, 32'd0);
    end
    chk_all_zero("idle");

    run_pass(4, 1'b0, -1, 0, -1, -1, 9);
    run_pass(4, 1'b1, 1, 7, 2, -1, 0);
    run_pass(4, 1'b1, -1, 0, -1, 2, 0);
    @(negedge clk);
    chk_all_zero("post_abort");
    run_pass(4, 1'b0, -1, 0, -1, -1, 9);

    sel = 1'b1;
    @(negedge clk);
    chk_all_zero("b_idle");
    run_pass(1, 1'b0, -1, 0, -1, -1, 3);
    run_pass(1, 1'b1, -1, 0, -1, -1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
